// File: rtl/qam16_ber_checker_pkg.sv
// Shared nibble type, FSM encodings and default delay-line depth for the QAM16 BER checker.
package qam16_ber_checker_pkg;

  localparam int NIB_W       = 4;
  localparam int MAX_DLY_DEF = 8;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/qam16_ber_checker_if.sv
// Symbol stream into the checker: one strobe qualifying a received and a reference nibble.
interface qam16_ber_checker_if;
  import qam16_ber_checker_pkg::*;

  logic    sym_vld;
  nibble_t rx_dat;
  nibble_t ref_dat;

  modport master (output sym_vld, rx_dat, ref_dat);
  modport slave  (input  sym_vld, rx_dat, ref_dat);

endinterface

// File: rtl/qam16_ber_checker_ref_delay.sv
// Reference history shift register with a latency-select read mux; combinational read, shifts on shift_en_i.
// No backpressure: shifts only on symbol strobes.
module qam16_ber_checker_ref_delay
  import qam16_ber_checker_pkg::*;
#(
  parameter int  MAX_DLY = MAX_DLY_DEF,
  localparam int SEL_W   = $clog2(MAX_DLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  nibble_t          ref_i,
  input  logic [SEL_W-1:0] dly_sel_i,
  output nibble_t          ref_d_o
);

  nibble_t          hist_q [MAX_DLY];
  logic [SEL_W-1:0] rd_idx;

  // hist_q[k] holds the reference from k+1 symbols ago, so a latency of N reads entry N-1.
  assign rd_idx  = dly_sel_i - SEL_W'(1);
  assign ref_d_o = (dly_sel_i == '0) ? ref_i : hist_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DLY; k++) hist_q[k] <= '0;
    end else if (shift_en_i) begin
      hist_q[0] <= ref_i;
      for (int k = 1; k < MAX_DLY; k++) hist_q[k] <= hist_q[k-1];
    end
  end

endmodule

// File: rtl/qam16_ber_checker.sv
// QAM16 BER checker: searches the rx/reference latency, locks, then counts symbol and bit errors.
// Results register one clk after the deciding symbol; no backpressure, idle cycles change nothing.
module qam16_ber_checker
  import qam16_ber_checker_pkg::*;
#(
  parameter int  MAX_DLY  = MAX_DLY_DEF,
  parameter int  LOCK_CNT = 8,
  parameter int  WIN      = 16,
  parameter int  LOSS_THR = 4,
  parameter int  CNT_W    = 16,
  localparam int SEL_W    = $clog2(MAX_DLY)
) (
  input  logic               clk,
  input  logic               rst_n,
  qam16_ber_checker_if.slave sym_if,
  input  logic               clear_i,
  output logic               locked_o,
  output logic [SEL_W-1:0]   dly_sel_o,
  output logic [CNT_W-1:0]   sym_cnt_o,
  output logic [CNT_W-1:0]   sym_err_cnt_o,
  output logic [CNT_W-1:0]   bit_err_cnt_o,
  output logic               err_pulse_o
);

  localparam int RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int ERR_W = $clog2(WIN + 1);

  function automatic logic [2:0] popcount4(input nibble_t v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] dly_sel_q, dly_sel_d, dly_next;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [ERR_W-1:0] werr_q, werr_d, werr_inc;
  logic [CNT_W-1:0] sym_q, sym_d, serr_q, serr_d, berr_q, berr_d;
  logic             pulse_q, pulse_d;
  nibble_t          ref_d, diff;
  logic             mismatch;

  qam16_ber_checker_ref_delay #(.MAX_DLY(MAX_DLY)) u_ref_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (sym_if.sym_vld),
    .ref_i      (sym_if.ref_dat),
    .dly_sel_i  (dly_sel_q),
    .ref_d_o    (ref_d)
  );

  assign diff     = sym_if.rx_dat ^ ref_d;
  assign mismatch = (diff != '0);
  assign werr_inc = werr_q + ERR_W'(mismatch);
  assign dly_next = (dly_sel_q == SEL_W'(MAX_DLY - 1)) ? '0 : dly_sel_q + SEL_W'(1);

  always_comb begin
    state_d   = state_q;
    dly_sel_d = dly_sel_q;
    run_d     = run_q;
    win_d     = win_q;
    werr_d    = werr_q;
    sym_d     = sym_q;
    serr_d    = serr_q;
    berr_d    = berr_q;
    pulse_d   = 1'b0;
    if (sym_if.sym_vld) begin
      if (state_q == ST_SEARCH) begin
        if (!mismatch) begin
          if (run_q == RUN_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d     = '0;
          dly_sel_d = dly_next;
        end
      end else begin
        pulse_d = mismatch;
        sym_d   = sat_add(sym_q, 3'd1);
        if (mismatch) begin
          serr_d = sat_add(serr_q, 3'd1);
          berr_d = sat_add(berr_q, popcount4(diff));
        end
        // The window's last symbol is included in the loss decision.
        if (win_q == WIN_W'(WIN - 1)) begin
          if (werr_inc >= ERR_W'(LOSS_THR)) begin
            state_d   = ST_SEARCH;
            dly_sel_d = dly_next;
          end
          win_d  = '0;
          werr_d = '0;
        end else begin
          win_d  = win_q + WIN_W'(1);
          werr_d = werr_inc;
        end
      end
    end
    if (clear_i) begin
      sym_d  = '0;
      serr_d = '0;
      berr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SEARCH;
      dly_sel_q <= '0;
      run_q     <= '0;
      win_q     <= '0;
      werr_q    <= '0;
      sym_q     <= '0;
      serr_q    <= '0;
      berr_q    <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_sel_q <= dly_sel_d;
      run_q     <= run_d;
      win_q     <= win_d;
      werr_q    <= werr_d;
      sym_q     <= sym_d;
      serr_q    <= serr_d;
      berr_q    <= berr_d;
      pulse_q   <= pulse_d;
    end
  end

  assign locked_o      = (state_q == ST_LOCKED);
  assign dly_sel_o     = dly_sel_q;
  assign sym_cnt_o     = sym_q;
  assign sym_err_cnt_o = serr_q;
  assign bit_err_cnt_o = berr_q;
  assign err_pulse_o   = pulse_q;

endmodule

// File: tb/tb_qam16_ber_checker.sv
// Scoreboard bench for qam16_ber_checker: a 16-bit and a 4-bit counter build share one symbol stream.
module tb_qam16_ber_checker;
  import qam16_ber_checker_pkg::*;

  typedef struct packed {
    logic        locked;
    logic [2:0]  dly;
    logic [15:0] sc;
    logic [15:0] sec;
    logic [15:0] bec;
    logic        pulse;
    logic        locked4;
    logic [2:0]  dly4;
    logic        pulse4;
    logic [3:0]  sc4;
    logic [3:0]  sec4;
    logic [3:0]  bec4;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n, clear;
  logic        locked, pulse, locked4, pulse4;
  logic [2:0]  dly, dly4;
  logic [15:0] sc, sec, bec;
  logic [3:0]  sc4, sec4, bec4;

  qam16_ber_checker_if sym_if ();

  always #5 clk = ~clk;

  qam16_ber_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sym_if(sym_if), .clear_i(clear),
    .locked_o(locked), .dly_sel_o(dly), .sym_cnt_o(sc), .sym_err_cnt_o(sec),
    .bit_err_cnt_o(bec), .err_pulse_o(pulse)
  );

  qam16_ber_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sym_if(sym_if), .clear_i(clear),
    .locked_o(locked4), .dly_sel_o(dly4), .sym_cnt_o(sc4), .sym_err_cnt_o(sec4),
    .bit_err_cnt_o(bec4), .err_pulse_o(pulse4)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t sb_q[$];
  obs_t got, want;

  bit         m_locked, m_pulse;
  int         m_dly, m_run, m_win, m_werr, m_sc, m_sec, m_bec;
  logic [3:0] m_hist [8];
  logic [3:0] d1, d2, d3;
  logic [3:0] t2_ref [40];

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  function automatic obs_t model_exp();
    obs_t e;
    e.locked = m_locked;  e.dly  = 3'(m_dly); e.pulse  = m_pulse;
    e.locked4 = m_locked; e.dly4 = 3'(m_dly); e.pulse4 = m_pulse;
    e.sc  = sat16(m_sc);  e.sec  = sat16(m_sec); e.bec  = sat16(m_bec);
    e.sc4 = sat4(m_sc);   e.sec4 = sat4(m_sec);  e.bec4 = sat4(m_bec);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.locked = locked;   o.dly  = dly;  o.pulse  = pulse;
    o.locked4 = locked4; o.dly4 = dly4; o.pulse4 = pulse4;
    o.sc  = sc;  o.sec  = sec;  o.bec  = bec;
    o.sc4 = sc4; o.sec4 = sec4; o.bec4 = bec4;
    return o;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_pulse = 0;
    m_dly = 0; m_run = 0; m_win = 0; m_werr = 0;
    m_sc = 0; m_sec = 0; m_bec = 0;
    for (int k = 0; k < 8; k++) m_hist[k] = 4'h0;
    d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    sb_q.delete();
  endtask

  // m_hist[k] is the reference from k+1 symbols ago; latency N compares against N symbols back.
  task automatic model_step(input logic [3:0] rx, input logic [3:0] rf, input bit vld, input bit clr);
    logic [3:0] rd;
    bit         mm;
    m_pulse = 0;
    if (vld) begin
      rd = (m_dly == 0) ? rf : m_hist[m_dly-1];
      mm = (rx != rd);
      if (!m_locked) begin
        if (!mm) begin
          if (m_run == 7) begin m_locked = 1; m_run = 0; end
          else m_run++;
        end else begin
          m_run = 0; m_dly = (m_dly + 1) % 8;
        end
      end else begin
        m_pulse = mm;
        m_sc++;
        if (mm) begin m_sec++; m_bec += $countones(rx ^ rd); m_werr++; end
        if (m_win == 15) begin
          if (m_werr >= 4) begin m_locked = 0; m_dly = (m_dly + 1) % 8; end
          m_win = 0; m_werr = 0;
        end else begin
          m_win++;
        end
      end
      for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = rf;
    end
    if (clr) begin m_sc = 0; m_sec = 0; m_bec = 0; end
  endtask

  // rx is the reference from three symbols back, xored with err_mask.
  task automatic send(input logic [3:0] ref_v, input logic [3:0] err_mask, input bit vld, input bit clr);
    logic [3:0] rx_v;
    rx_v = vld ? (d3 ^ err_mask) : 4'($urandom_range(15));
    @(negedge clk);
    sym_if.sym_vld = vld;
    sym_if.ref_dat = ref_v;
    sym_if.rx_dat  = rx_v;
    clear          = clr;
    model_step(rx_v, ref_v, vld, clr);
    sb_q.push_back(model_exp());
    if (vld) begin d3 = d2; d2 = d1; d1 = ref_v; end
    @(posedge clk);
    #1;
    sym_if.sym_vld = 1'b0;
    clear          = 1'b0;
  endtask

  task automatic run_stream(input string tag, output int dut_at, output int mdl_at);
    dut_at = -1;
    mdl_at = -1;
    for (int k = 0; k < 40; k++) begin
      send(t2_ref[k], 4'h0, 1'b1, 1'b0);
      want = sb_q.pop_front(); got = sample(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL %s sym %0d: got %h expected %h", tag, k, got, want);
      end
      if (dut_at < 0 && got.locked === 1'b1) dut_at = k;
      if (mdl_at < 0 && want.locked) mdl_at = k;
      if (k % 7 == 3) begin
        send(4'h0, 4'h0, 1'b0, 1'b0);
        want = sb_q.pop_front(); got = sample(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL %s idle after %0d: got %h expected %h", tag, k, got, want);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0;
    sym_if.sym_vld = 1'b0; sym_if.rx_dat = 4'h0; sym_if.ref_dat = 4'h0;
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", got); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int da, ma;
    run_stream("lock", da, ma);
    checks++;
    if (da !== 10 || ma !== 10) begin
      errors++; $display("FAIL lock_index: dut %0d model %0d expected 10", da, ma);
    end
    checks++;
    if (locked !== 1'b1 || dly !== 3'd3 || sc !== 16'd29 || sec !== 16'd0 || bec !== 16'd0) begin
      errors++;
      $display("FAIL lock_end: locked %b dly %0d sc %0d sec %0d bec %0d expected 1 3 29 0 0",
               locked, dly, sc, sec, bec);
    end
  endtask

  task automatic test_single_error();
    send(4'($urandom_range(15)), 4'b0101, 1'b1, 1'b0);
    want = sb_q.pop_front(); got = sample(); checks++;
    if (got !== want) begin errors++; $display("FAIL err_sym: got %h expected %h", got, want); end
    checks++;
    if (sec !== 16'd1 || bec !== 16'd2 || pulse !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL err_counts: sec %0d bec %0d pulse %b locked %b expected 1 2 1 1", sec, bec, pulse, locked);
    end
    send(4'h0, 4'h0, 1'b0, 1'b0);
    want = sb_q.pop_front(); got = sample(); checks++;
    if (got !== want || pulse !== 1'b0) begin
      errors++; $display("FAIL err_pulse_width: got %h expected %h", got, want);
    end
  endtask

  task automatic test_loss_relock();
    int  prev_dly;
    bit  seen_wrap;
    for (int n = 0; n < 16 && m_win != 0; n++) begin
      send(4'($urandom_range(15)), 4'h0, 1'b1, 1'b0);
      want = sb_q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL align %0d: got %h expected %h", n, got, want); end
    end
    for (int w = 0; w < 16; w++) begin
      send(4'($urandom_range(15)), (w == 1 || w == 4 || w == 8 || w == 15) ? 4'hF : 4'h0, 1'b1, 1'b0);
      want = sb_q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL window %0d: got %h expected %h", w, got, want); end
      if (w == 14) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL early_loss: locked %b expected 1", locked); end
      end
    end
    checks++;
    if (locked !== 1'b0 || dly !== 3'd4) begin
      errors++; $display("FAIL loss: locked %b dly %0d expected 0 4", locked, dly);
    end
    prev_dly = 4; seen_wrap = 0;
    for (int n = 0; n < 100; n++) begin
      send(4'($urandom_range(15)), 4'h0, 1'b1, 1'b0);
      want = sb_q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL relock %0d: got %h expected %h", n, got, want); end
      if (prev_dly == 7 && got.dly === 3'd0) seen_wrap = 1;
      prev_dly = int'(got.dly);
      if (got.locked === 1'b1) break;
    end
    checks++;
    if (!seen_wrap || locked !== 1'b1 || dly !== 3'd3) begin
      errors++; $display("FAIL relock_end: wrap %b locked %b dly %0d expected 1 1 3", seen_wrap, locked, dly);
    end
  endtask

  task automatic test_saturate_clear();
    for (int n = 0; n < 20; n++) begin
      send(4'($urandom_range(15)), 4'h0, 1'b1, 1'b0);
      want = sb_q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL sat %0d: got %h expected %h", n, got, want); end
    end
    checks++;
    if (sc4 !== 4'hF || locked4 !== 1'b1) begin
      errors++; $display("FAIL sat_hold: sc4 %0d locked4 %b expected 15 1", sc4, locked4);
    end
    send(4'($urandom_range(15)), 4'h0, 1'b1, 1'b1);
    want = sb_q.pop_front(); got = sample(); checks++;
    if (got !== want) begin errors++; $display("FAIL clear_sym: got %h expected %h", got, want); end
    checks++;
    if ({sc, sec, bec, sc4, sec4, bec4} !== '0 || locked !== 1'b1) begin
      errors++; $display("FAIL clear_counts: got %h locked %b expected 0 1", {sc, sec, bec, sc4, sec4, bec4}, locked);
    end
  endtask

  task automatic test_async_reset();
    int da, ma;
    for (int n = 0; n < 5; n++) begin
      send(4'($urandom_range(15)), 4'h0, 1'b1, 1'b0);
      want = sb_q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL pre_reset %0d: got %h expected %h", n, got, want); end
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", got); end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_stream("rerun", da, ma);
    checks++;
    if (da !== 10 || ma !== 10) begin
      errors++; $display("FAIL relock_index: dut %0d model %0d expected 10", da, ma);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // A nonzero first reference makes latencies 0..2 each reject on their first symbol.
    t2_ref[0] = 4'($urandom_range(15, 1));
    for (int k = 1; k < 40; k++) t2_ref[k] = 4'($urandom_range(15));
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_saturate_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
